// File: rtl/mult_div_unit.sv
// mult_div_unit: E-stage multi-cycle multiply/divide with HI/LO registers.
// Optional MDU_CANCEL_EN adds a cancel input that flushes an in-flight op.
module mult_div_unit #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
`ifdef MDU_CANCEL_EN
  input  logic        cancel,
`endif
  input  logic [3:0]  md_op,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic        busy,
  output logic        start_or_busy,
  output logic [31:0] md_result,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);
  logic [3:0]  r_cnt;
  logic [31:0] r_hi, r_lo, r_thi, r_tlo;
  logic        w_cancel, w_start, w_is_md;
  logic [63:0] w_smul, w_umul, w_res;
  logic [31:0] w_abs_a, w_abs_b, w_mq, w_mr, w_sq, w_sr, w_uq, w_ur;
`ifdef MDU_CANCEL_EN
  assign w_cancel = cancel;
`else
  assign w_cancel = 1'b0;
`endif
  assign w_is_md = (md_op >= 4'd1) && (md_op <= 4'd4);
  assign w_start = (r_cnt == 4'd0) && w_is_md && !w_cancel;
  assign w_smul = {{32{srcA[31]}}, srcA} * {{32{srcB[31]}}, srcB};
  assign w_umul = {32'b0, srcA} * {32'b0, srcB};
  // signed divide on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000
  assign w_abs_a = srcA[31] ? -srcA : srcA;
  assign w_abs_b = srcB[31] ? -srcB : srcB;
  assign w_mq = w_abs_a / w_abs_b;
  assign w_mr = w_abs_a % w_abs_b;
  assign w_sq = (srcA[31] ^ srcB[31]) ? -w_mq : w_mq;
  assign w_sr = srcA[31] ? -w_mr : w_mr;
  assign w_uq = srcA / srcB;
  assign w_ur = srcA % srcB;
  always_comb begin
    w_res = {r_hi, r_lo};
    if (md_op == 4'd1) w_res = w_smul;
    else if (md_op == 4'd2) w_res = w_umul;
    else if (md_op == 4'd3 && srcB != 32'd0) w_res = {w_sr, w_sq};
    else if (md_op == 4'd4 && srcB != 32'd0) w_res = {w_ur, w_uq};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_thi <= '0;
      r_tlo <= '0;
    end else if (w_cancel) begin
      r_cnt <= '0;
    end else if (r_cnt == 4'd1) begin
      r_hi  <= r_thi;
      r_lo  <= r_tlo;
      r_cnt <= '0;
    end else if (r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end else if (w_start) begin
      {r_thi, r_tlo} <= w_res;
      r_cnt <= (md_op <= 4'd2) ? 4'(MULT_LAT) : 4'(DIV_LAT);
    end else if (md_op == 4'd7) begin
      r_hi <= srcA;
    end else if (md_op == 4'd8) begin
      r_lo <= srcA;
    end
  end
  assign busy          = (r_cnt != 4'd0);
  assign start_or_busy = busy || w_is_md;
  assign md_result     = (md_op == 4'd5) ? r_hi : (md_op == 4'd6) ? r_lo : 32'd0;
  assign hi_out        = r_hi;
  assign lo_out        = r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors with hand-computed HI/LO results.
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  md_op;
  logic [31:0] srcA, srcB;
  logic        busy, start_or_busy;
  logic [31:0] md_result, hi_out, lo_out;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk),
    .reset(reset),
`ifdef MDU_CANCEL_EN
    .cancel(1'b0),
`endif
    .md_op(md_op),
    .srcA(srcA),
    .srcB(srcB),
    .busy(busy),
    .start_or_busy(start_or_busy),
    .md_result(md_result),
    .hi_out(hi_out),
    .lo_out(lo_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // issue op, check busy/old HI each busy cycle (with an mfhi probe), then final HI/LO
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, b,
                        input int lat, input logic [31:0] old_hi, exp_hi, exp_lo);
    md_op = op; srcA = a; srcB = b;
    #1;
    check({tag, "_sob"}, 32'(start_or_busy), 32'd1);
    step();
    md_op = 4'd0;
    for (int i = 0; i < lat; i++) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_hold_hi"}, hi_out, old_hi);
      if (i == 1) begin
        md_op = 4'd5;
        #1;
        check({tag, "_mfhi_busy"}, md_result, old_hi);
        md_op = 4'd0;
      end
      step();
    end
    check({tag, "_done"}, 32'(busy), 32'd0);
    check({tag, "_hi"}, hi_out, exp_hi);
    check({tag, "_lo"}, lo_out, exp_lo);
  endtask

  initial begin
    reset = 1'b1; md_op = 4'd0; srcA = '0; srcB = '0;
    step(); step();
    reset = 1'b0;
    #1;
    check("rst_hi", hi_out, 32'd0);
    check("rst_lo", lo_out, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sob", 32'(start_or_busy), 32'd0);

    run_op("mult", 4'd1, 32'hFFFFFFFE, 32'd3, 5, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu", 4'd2, 32'hFFFFFFFF, 32'd2, 5, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE);
    run_op("div", 4'd3, 32'hFFFFFFF9, 32'd2, 10, 32'h1, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'hFFFFFFFF, 32'h0, 32'h80000000);

    md_op = 4'd7; srcA = 32'h12345678;
    step();
    md_op = 4'd6;
    #1;
    check("mthi_busy", 32'(busy), 32'd0);
    check("mthi_hi", hi_out, 32'h12345678);
    check("mflo", md_result, 32'h80000000);
    run_op("divu0", 4'd4, 32'd5, 32'd0, 10, 32'h12345678, 32'h12345678, 32'h80000000);

    md_op = 4'd3; srcA = 32'd100; srcB = 32'd7;
    step();
    md_op = 4'd0;
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_hi", hi_out, 32'd0);
    check("midrst_lo", lo_out, 32'd0);
    step();
    check("midrst_nocommit", lo_out, 32'd0);

    run_op("b2b_mult", 4'd1, 32'd6, 32'd7, 5, 32'h0, 32'h0, 32'd42);
    run_op("b2b_divu", 4'd4, 32'd100, 32'd7, 10, 32'h0, 32'd2, 32'd14);
    md_op = 4'd8; srcA = 32'hCAFEBABE;
    step();
    md_op = 4'd9;
    #1;
    check("mtlo_lo", lo_out, 32'hCAFEBABE);
    check("mtlo_hi", hi_out, 32'd2);
    check("mtlo_busy", 32'(busy), 32'd0);
    check("op9_result", md_result, 32'd0);
    check("op9_sob", 32'(start_or_busy), 32'd0);
    md_op = 4'd0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- E-stage multiply/divide unit with architectural HI/LO registers, built as the next extension of the 5-stage pipeline.
- Sits beside the ALU. It takes already-forwarded E-stage operands (srcA_fore/srcB_fore equivalents) plus a decoded MDU opcode.
- Runs multi-cycle mult/div and reports busy to the hazard unit, which stalls D-stage MDU instructions.
- Supplies the HI/LO read value to the E-stage result mux for mfhi/mflo.

Parameters:
- MULT_LAT, 5, busy cycles for mult/multu (range 1..15)
- DIV_LAT, 10, busy cycles for div/divu (range 1..15)

Ports:
- clk  input  1  pipeline clock
- reset  input  1  synchronous, active-high reset
- md_op  input  4  decoded op: 0 none, 1 mult, 2 multu, 3 div, 4divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 treated as none
- srcA  input  32  forwarded rs value
- srcB  input  32  forwarded rt value
- busy  output  1  registered; an operation is in flight
- start_or_busy  output  1  combinational; busy, or md_op is in 1..4 this cycle (hazard unit input)
- md_result  output  32  combinational; HI when md_op=5, LO when md_op=6, else 0
- hi_out  output  32  current HI register
- lo_out  output  32  current LO register

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high.
- Reset values: HI=0, LO=0, cnt=0, busy=0, temp regs=0. reset in mid-operation aborts it; HI/LO are not committed.
- Internal state: 4-bit cnt, temp_hi, temp_lo. busy = (cnt != 0).
- Start rule: at a posedge with cnt==0 and md_op in 1..4:
  - compute the full result into temp_hi/temp_lo;
  - load cnt with MULT_LAT (ops 1, 2) or DIV_LAT (ops 3, 4).
  - HI/LO are unchanged at this edge.
- Counting: at a posedge with cnt>1, cnt decrements.
- Commit: at a posedge with cnt==1, HI<=temp_hi, LO<=temp_lo, cnt<=0.
  - busy is therefore high for exactly LAT cycles after the start edge.
  - The new HI/LO are visible in the cycle after busy falls.
- md_op while busy: any md_op 1..4 or 7..8 arriving while cnt!=0 is ignored; the hazard unit guarantees this never occurs.
  - mfhi/mflo while busy return the old HI/LO (stall is the hazard unit's job).
- mthi/mtlo (cnt==0): HI<=srcA or LO<=srcA at the edge. Single-cycle, busy stays low.
- mult (signed): {HI,LO} = signed 64-bit srcA*srcB.
- multu: {HI,LO} = unsigned 64-bit srcA*srcB.
- div (signed):
  - LO = quotient truncated toward zero, HI = remainder carrying the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- divu: unsigned quotient and remainder.
- Divide by zero (srcB==0 for div/divu): the op still occupies DIV_LAT busy cycles. temp_hi/temp_lo are loaded with the current HI/LO, so HI/LO end up unchanged.
- Back-to-back: a new start is accepted at the posedge immediately after commit, i.e. the first cycle with busy=0.

Optional Feature:
- Macro: MDU_CANCEL_EN
- When defined:
  - adds input port cancel (1 bit), used for P7 exception flush;
  - at a posedge with cancel=1, cnt<=0 and no commit occurs;
  - a start or mthi/mtlo presented in the same cycle as cancel is also dropped;
  - cancel has priority over commit at cnt==1.
- When undefined: no cancel port; behaviour is exactly as above.

Test Plan:
- Reset then idle: hold reset 2 cycles -> hi_out=lo_out=0, busy=0, start_or_busy=0.
- mult: srcA=0xFFFFFFFE (-2), srcB=3, md_op=1 for one cycle, then md_op=0 (MULT_LAT=5):
  - busy=1 for cycles 1..5 after the start edge;
  - afterwards HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu: srcA=0xFFFFFFFF, srcB=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- div: srcA=0xFFFFFFF9 (-7), srcB=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 busy cycles.
  - mfhi issued during busy returns the previous HI.
  - Overflow case 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero and mid-op reset:
  - mthi 0x12345678, then divu srcB=0 -> busy 10 cycles, HI stays 0x12345678;
  - a separate run asserts reset at cycle 3 of a div -> busy=0, HI/LO=0.
- Back-to-back and write ops: mult committed, then divu issued the first idle cycle, then mtlo 0xCAFEBABE:
  - each completes in order;
  - final LO=0xCAFEBABE, HI = divu remainder.
